// File: rtl/bos_spi_arbiter_pkg.sv
// Shared definitions for the BOS SPI arbiter: frame layout, rw encoding,
// FSM state encoding and the frame builder.
package bos_pkg;

    localparam int RW_BIT    = 23;
    localparam int ADDR_MSB  = 22;
    localparam int ADDR_LSB  = 16;
    localparam int DATA_MSB  = 13;
    localparam int DATA_LSB  = 0;
    localparam int FRAME_W   = 24;
    localparam int DATA_W    = 14;
    localparam int ADDR_W    = 7;
    localparam int CHIP_W    = 4;
    localparam int NCHIP_MAX = 16;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_XFER   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic [FRAME_W-1:0] build_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata
    );
        logic [FRAME_W-1:0] frame;
        frame                    = {FRAME_W{1'b0}};
        frame[RW_BIT]            = rw;
        frame[ADDR_MSB:ADDR_LSB] = addr;
        if (rw == RW_READ) begin
            frame[DATA_MSB:DATA_LSB] = {DATA_W{1'b0}};
        end else begin
            frame[DATA_MSB:DATA_LSB] = wdata;
        end
        return frame;
    endfunction

endpackage

// File: rtl/bos_spi_arbiter_if.sv
// Requester-side and SPI-master-side signal bundle of the BOS SPI arbiter.
interface bos_spi_arbiter_if
    import bos_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int NCHIP = 10
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_rw;
    logic [CHIP_W*NREQ-1:0] req_chip;
    logic [ADDR_W*NREQ-1:0] req_addr;
    logic [DATA_W*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]        ack;
    logic                   err;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;
    logic [FRAME_W-1:0]     spi_data;
    logic                   spi_ena;
    logic                   spi_busy;
    logic                   spi_n_cs;
    logic [FRAME_W-1:0]     spi_rx;
    logic [NCHIP-1:0]       sl;

    modport slave (
        input  req, req_rw, req_chip, req_addr, req_wdata,
        input  spi_busy, spi_n_cs, spi_rx,
        output ack, err, rdata, busy, spi_data, spi_ena, sl
    );

    modport master (
        output req, req_rw, req_chip, req_addr, req_wdata,
        output spi_busy, spi_n_cs, spi_rx,
        input  ack, err, rdata, busy, spi_data, spi_ena, sl
    );
endinterface

// File: rtl/bos_spi_arbiter_rr.sv
// Combinational round-robin picker: the first active request after
// last_grant (wrapping) wins.
module bos_rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int GW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [GW-1:0]   last_grant,
    output logic [GW-1:0]   grant,
    output logic            any_req
);

    logic [GW-1:0] idx_s;

    // Scan from lowest to highest priority so the nearest requester wins last.
    always_comb begin
        grant   = last_grant;
        idx_s   = last_grant;
        any_req = |req;
        for (int i = NREQ; i >= 1; i--) begin
            idx_s = GW'((int'(last_grant) + i) % NREQ);
            if (req[idx_s]) begin
                grant = idx_s;
            end else begin
                grant = grant;
            end
        end
    end

endmodule

// File: rtl/bos_spi_arbiter.sv
// Shares one 24-bit SPI master among NREQ requesters: round-robin grant,
// frame formatting, launch, read-data return and per-chip select demux.
module bos_spi_arbiter
    import bos_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int NCHIP = 10
) (
    input  logic               clk,
    input  logic               rst,
    bos_spi_arbiter_if.slave   bus
);

    localparam int GW = $clog2(NREQ);

    state_t             state_r;
    state_t             next_state_s;
    logic [GW-1:0]      grant_s;
    logic               any_req_s;
    logic [GW-1:0]      grant_r;
    logic [GW-1:0]      last_grant_r;
    logic [CHIP_W-1:0]  chip_r;
    logic [NREQ-1:0]    ack_r;
    logic               err_r;
    logic [DATA_W-1:0]  rdata_r;
    logic               busy_r;
    logic [FRAME_W-1:0] spi_data_r;
    logic               spi_ena_r;
    logic [NCHIP-1:0]   sl_s;
    logic [CHIP_W-1:0]  chip_a [NREQ];
    logic [ADDR_W-1:0]  addr_a [NREQ];
    logic [DATA_W-1:0]  wdata_a [NREQ];
    logic               chip_ok_s;
    logic               unused_rx_s;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign chip_a[g]  = bus.req_chip[CHIP_W*g +: CHIP_W];
        assign addr_a[g]  = bus.req_addr[ADDR_W*g +: ADDR_W];
        assign wdata_a[g] = bus.req_wdata[DATA_W*g +: DATA_W];
    end

    bos_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req        (bus.req),
        .last_grant (last_grant_r),
        .grant      (grant_s),
        .any_req    (any_req_s)
    );

    assign chip_ok_s   = ({1'b0, chip_a[grant_s]} < 5'(NCHIP));
    assign unused_rx_s = ^bus.spi_rx[FRAME_W-1:DATA_W];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state. DONE exits only after its ack cycle, so an invalid-chip
    // grant spends one silent DONE cycle before acknowledging.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    next_state_s = chip_ok_s ? ST_LAUNCH : ST_DONE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (bus.spi_busy) begin
                    next_state_s = ST_XFER;
                end else begin
                    next_state_s = ST_LAUNCH;
                end
            end
            ST_XFER: begin
                if (!bus.spi_busy) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_XFER;
                end
            end
            ST_DONE: begin
                if (|ack_r) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Registered outputs and latched transfer fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_r      <= {GW{1'b0}};
            last_grant_r <= GW'(NREQ - 1);
            chip_r       <= {CHIP_W{1'b0}};
            ack_r        <= {NREQ{1'b0}};
            err_r        <= 1'b0;
            rdata_r      <= {DATA_W{1'b0}};
            busy_r       <= 1'b0;
            spi_data_r   <= {FRAME_W{1'b0}};
            spi_ena_r    <= 1'b0;
        end else begin
            busy_r    <= (next_state_s != ST_IDLE);
            spi_ena_r <= (state_r == ST_IDLE) && (next_state_s == ST_LAUNCH);
            ack_r     <= {NREQ{1'b0}};
            if ((next_state_s == ST_DONE) && (state_r != ST_IDLE)) begin
                ack_r[grant_r] <= 1'b1;
            end else begin
                ack_r <= {NREQ{1'b0}};
            end
            if ((state_r == ST_IDLE) && (next_state_s != ST_IDLE)) begin
                grant_r <= grant_s;
                chip_r  <= chip_a[grant_s];
                err_r   <= !chip_ok_s;
                rdata_r <= {DATA_W{1'b0}};
                if (chip_ok_s) begin
                    spi_data_r <= build_frame(bus.req_rw[grant_s], addr_a[grant_s],
                                              wdata_a[grant_s]);
                end else begin
                    spi_data_r <= spi_data_r;
                end
            end else if ((state_r == ST_XFER) && !bus.spi_busy) begin
                rdata_r <= bus.spi_rx[DATA_MSB:DATA_LSB];
            end else if ((state_r == ST_DONE) && (|ack_r)) begin
                last_grant_r <= grant_r;
            end else begin
                grant_r <= grant_r;
            end
        end
    end

    // Route the master's chip select to the latched chip while a transfer is live.
    always_comb begin
        sl_s = {NCHIP{1'b1}};
        if ((state_r == ST_LAUNCH) || (state_r == ST_XFER)) begin
            for (int k = 0; k < NCHIP; k++) begin
                if (chip_r == CHIP_W'(k)) begin
                    sl_s[k] = bus.spi_n_cs;
                end else begin
                    sl_s[k] = 1'b1;
                end
            end
        end else begin
            sl_s = {NCHIP{1'b1}};
        end
    end

    assign bus.ack      = ack_r;
    assign bus.err      = err_r;
    assign bus.rdata    = rdata_r;
    assign bus.busy     = busy_r;
    assign bus.spi_data = spi_data_r;
    assign bus.spi_ena  = spi_ena_r;
    assign bus.sl       = sl_s;

endmodule
